// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the instruction encoder: class codes, opcodes,
// branch func3 values and FSM state encoding.
package instr_encoder_pkg;

  typedef enum logic [2:0] {
    CLS_R    = 3'd0,
    CLS_I    = 3'd1,
    CLS_S    = 3'd2,
    CLS_B    = 3'd3,
    CLS_U    = 3'd4,
    CLS_J    = 3'd5,
    CLS_LW   = 3'd6,
    CLS_JALR = 3'd7
  } instr_class_t;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_U    = 7'b0110111;
  localparam logic [6:0] OP_J    = 7'b1101111;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  // Branch func3 as decoded by our pipeline (not the standard RISC-V map).
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLT = 3'b010;
  localparam logic [2:0] F3_BGE = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ENC  = 2'd1,
    ST_WR   = 2'd2,
    ST_FULL = 2'd3
  } state_t;

  function automatic logic is_branch_f3(input logic [2:0] f3);
    return (f3 == F3_BEQ) || (f3 == F3_BNE) || (f3 == F3_BLT) || (f3 == F3_BGE);
  endfunction

endpackage

// File: rtl/instr_encoder_packer.sv
// Combinational field packer: class + fields + immediate -> 32-bit word.
// Fields a class does not use stay zero.
module instr_packer
  import instr_encoder_pkg::*;
(
  input  logic [2:0]  cls,
  input  logic [2:0]  func3,
  input  logic        func7b5,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] word
);

  always_comb begin
    word = '0;
    case (instr_class_t'(cls))
      CLS_R: begin
        word[6:0]   = OP_R;
        word[11:7]  = rd;
        word[14:12] = func3;
        word[19:15] = rs1;
        word[24:20] = rs2;
        word[30]    = func7b5;
      end
      CLS_I: begin
        word[6:0]   = OP_I;
        word[11:7]  = rd;
        word[14:12] = func3;
        word[19:15] = rs1;
        word[31:20] = imm[11:0];
      end
      CLS_S: begin
        word[6:0]   = OP_S;
        word[11:7]  = imm[4:0];
        word[14:12] = func3;
        word[19:15] = rs1;
        word[24:20] = rs2;
        word[31:25] = imm[11:5];
      end
      CLS_B: begin
        word[6:0]   = OP_B;
        word[7]     = imm[11];
        word[11:8]  = imm[4:1];
        word[14:12] = func3;
        word[19:15] = rs1;
        word[24:20] = rs2;
        word[30:25] = imm[10:5];
        word[31]    = imm[12];
      end
      CLS_U: begin
        word[6:0]   = OP_U;
        word[11:7]  = rd;
        word[31:12] = imm[31:12];
      end
      CLS_J: begin
        word[6:0]   = OP_J;
        word[11:7]  = rd;
        word[19:12] = imm[19:12];
        word[20]    = imm[11];
        word[30:21] = imm[10:1];
        word[31]    = imm[20];
      end
      CLS_LW: begin
        // func3 deliberately left at 000 for loads and JALR.
        word[6:0]   = OP_LW;
        word[11:7]  = rd;
        word[19:15] = rs1;
        word[31:20] = imm[11:0];
      end
      CLS_JALR: begin
        word[6:0]   = OP_JALR;
        word[11:7]  = rd;
        word[19:15] = rs1;
        word[31:20] = imm[11:0];
      end
      default: word = '0;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: captures fields, packs them, writes one word per
// 3 cycles into instruction memory. INSTR_ENCODER_CHECK_EN enables
// immediate range checking. Handshake: in_valid & in_ready on a rising edge
// transfers all in_* fields; in_ready is high only in IDLE.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 256
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2:0]              in_class,
  input  logic [2:0]              in_func3,
  input  logic                    in_func7b5,
  input  logic [4:0]              in_rd,
  input  logic [4:0]              in_rs1,
  input  logic [4:0]              in_rs2,
  input  logic [31:0]             in_imm,
  output logic                    imem_we,
  output logic [31:0]             imem_addr,
  output logic [31:0]             imem_wdata,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    err,
  output logic [1:0]              state
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_t          state_q;
  logic [2:0]      cls_q;
  logic [2:0]      f3_q;
  logic            f7_q;
  logic [4:0]      rd_q;
  logic [4:0]      rs1_q;
  logic [4:0]      rs2_q;
  logic [31:0]     imm_q;
  logic [31:0]     wdata_q;
  logic [CW-1:0]   count_q;
  logic            err_q;
  logic [31:0]     word;
  logic [CW-1:0]   count_inc;
  logic            branch_bad;
  logic            imm_bad;

  instr_packer u_packer (
    .cls     (cls_q),
    .func3   (f3_q),
    .func7b5 (f7_q),
    .rd      (rd_q),
    .rs1     (rs1_q),
    .rs2     (rs2_q),
    .imm     (imm_q),
    .word    (word)
  );

  assign count_inc  = count_q + CW'(1);
  assign branch_bad = (instr_class_t'(cls_q) == CLS_B) && !is_branch_f3(f3_q);

`ifdef INSTR_ENCODER_CHECK_EN
  logic fits12, fits13, fits21;
  assign fits12 = (&imm_q[31:11]) | ~(|imm_q[31:11]);
  assign fits13 = (&imm_q[31:12]) | ~(|imm_q[31:12]);
  assign fits21 = (&imm_q[31:20]) | ~(|imm_q[31:20]);

  always_comb begin
    imm_bad = 1'b0;
    case (instr_class_t'(cls_q))
      CLS_I, CLS_S, CLS_LW, CLS_JALR: imm_bad = !fits12;
      CLS_B:                          imm_bad = !fits13 || imm_q[0];
      CLS_J:                          imm_bad = !fits21 || imm_q[0];
      CLS_U:                          imm_bad = |imm_q[11:0];
      default:                        imm_bad = 1'b0;
    endcase
  end
`else
  assign imm_bad = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cls_q   <= '0;
      f3_q    <= '0;
      f7_q    <= 1'b0;
      rd_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      imm_q   <= '0;
      wdata_q <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else if (clear) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            cls_q   <= in_class;
            f3_q    <= in_func3;
            f7_q    <= in_func7b5;
            rd_q    <= in_rd;
            rs1_q   <= in_rs1;
            rs2_q   <= in_rs2;
            imm_q   <= in_imm;
            state_q <= ST_ENC;
          end
        end
        ST_ENC: begin
          wdata_q <= word;
          if (branch_bad || imm_bad) err_q <= 1'b1;
          state_q <= imm_bad ? ST_IDLE : ST_WR;
        end
        ST_WR: begin
          count_q <= count_inc;
          state_q <= (count_inc == CW'(DEPTH)) ? ST_FULL : ST_IDLE;
        end
        ST_FULL: state_q <= ST_FULL;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // clear gates the write strobe so a word sitting in WR is dropped.
  assign imem_we    = (state_q == ST_WR) && !clear;
  assign imem_addr  = BASE_ADDR + (32'(count_q) << 2);
  assign imem_wdata = wdata_q;
  assign in_ready   = (state_q == ST_IDLE);
  assign full       = (state_q == ST_FULL);
  assign count      = count_q;
  assign err        = err_q;
  assign state      = state_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder (DEPTH=4); honours
// INSTR_ENCODER_CHECK_EN for the immediate-range scenario.
module tb_instr_encoder;

  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_class;
  logic [2:0]  in_func3;
  logic        in_func7b5;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic [2:0]  count;
  logic        full;
  logic        err;
  logic [1:0]  state;

  logic [63:0] exp_q[$];
  logic [63:0] exp_v;
  int          n_cmp;
  int          n_bad;
  int          n_writes;
  int          exp_count;

  instr_encoder #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_class   (in_class),
    .in_func3   (in_func3),
    .in_func7b5 (in_func7b5),
    .in_rd      (in_rd),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_imm     (in_imm),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .count      (count),
    .full       (full),
    .err        (err),
    .state      (state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: sim time expired, required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] model_word(input logic [2:0] c, input logic [2:0] f3,
                                             input logic f7, input logic [4:0] rd,
                                             input logic [4:0] rs1, input logic [4:0] rs2,
                                             input logic [31:0] imm);
    case (c)
      3'd0:    return {1'b0, f7, 5'b0, rs2, rs1, f3, rd, 7'b0110011};
      3'd1:    return {imm[11:0], rs1, f3, rd, 7'b0010011};
      3'd2:    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
      3'd3:    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
      3'd4:    return {imm[31:12], rd, 7'b0110111};
      3'd5:    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
      3'd6:    return {imm[11:0], rs1, 3'b000, rd, 7'b0000011};
      default: return {imm[11:0], rs1, 3'b000, rd, 7'b1100111};
    endcase
  endfunction

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n === 1'b1 && imem_we === 1'b1) begin
      n_writes++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_write: addr=%h data=%h, required no write", imem_addr, imem_wdata);
      end else begin
        exp_v = exp_q.pop_front();
        if ({imem_addr, imem_wdata} !== exp_v) begin
          n_bad++;
          $display("FAIL write: addr=%h data=%h, required addr=%h data=%h",
                   imem_addr, imem_wdata, exp_v[63:32], exp_v[31:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [2:0] c, input logic [2:0] f3, input logic f7,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [31:0] imm, input logic [31:0] word, input bit push);
    int n;
    n = 0;
    @(negedge clk);
    in_class = c; in_func3 = f3; in_func7b5 = f7;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      n_cmp++; n_bad++;
      $display("FAIL handshake_timeout: in_ready=%b, required 1", in_ready);
      in_valid = 1'b0;
    end else begin
      if (push) begin
        exp_q.push_back({BASE + 32'(exp_count) * 32'd4, word});
        exp_count++;
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d writes outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    exp_count = 0;
  endtask

  task automatic wait_cycles(input int k);
    repeat (k) @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    wait_cycles(3);
    n_cmp += 8;
    if (state !== 2'd0)      begin n_bad++; $display("FAIL reset_state: %0d, required 0", state); end
    if (in_ready !== 1'b1)   begin n_bad++; $display("FAIL reset_in_ready: %b, required 1", in_ready); end
    if (imem_we !== 1'b0)    begin n_bad++; $display("FAIL reset_we: %b, required 0", imem_we); end
    if (imem_addr !== BASE)  begin n_bad++; $display("FAIL reset_addr: %h, required %h", imem_addr, BASE); end
    if (imem_wdata !== 32'h0) begin n_bad++; $display("FAIL reset_wdata: %h, required 0", imem_wdata); end
    if (count !== 3'd0)      begin n_bad++; $display("FAIL reset_count: %0d, required 0", count); end
    if (full !== 1'b0)       begin n_bad++; $display("FAIL reset_full: %b, required 0", full); end
    if (err !== 1'b0)        begin n_bad++; $display("FAIL reset_err: %b, required 0", err); end
    @(negedge clk);
    rst_n = 1'b1;
    wait_cycles(1);
  endtask

  task automatic test_r_add();
    send(3'd0, 3'b000, 1'b0, 5'd1, 5'd2, 5'd3, 32'h0, 32'h003100B3, 1'b1);
    n_cmp++;
    if (imem_we !== 1'b0) begin n_bad++; $display("FAIL latency_early: we=%b, required 0", imem_we); end
    @(posedge clk); #1;
    n_cmp += 3;
    if (imem_we !== 1'b1)           begin n_bad++; $display("FAIL latency_we: %b, required 1", imem_we); end
    if (imem_addr !== 32'h0)        begin n_bad++; $display("FAIL r_add_addr: %h, required 0", imem_addr); end
    if (imem_wdata !== 32'h003100B3) begin n_bad++; $display("FAIL r_add_wdata: %h, required 003100b3", imem_wdata); end
    @(posedge clk); #1;
    n_cmp++;
    if (imem_we !== 1'b0) begin n_bad++; $display("FAIL we_pulse_width: %b, required 0", imem_we); end
    drain();
    n_cmp++;
    if (count !== 3'd1) begin n_bad++; $display("FAIL r_add_count: %0d, required 1", count); end
  endtask

  task automatic test_vectors();
    do_clear();
    send(3'd1, 3'b000, 1'b0, 5'd5, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'hFFF00293, 1'b1);
    send(3'd3, 3'b001, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFF8, 32'hFE209CE3, 1'b1);
    drain();
    n_cmp += 2;
    if (err !== 1'b0)   begin n_bad++; $display("FAIL vec_err: %b, required 0", err); end
    if (count !== 3'd2) begin n_bad++; $display("FAIL vec_count: %0d, required 2", count); end
    do_clear();
    send(3'd5, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048, 32'h001000EF, 1'b1);
    send(3'd4, 3'b000, 1'b0, 5'd7, 5'd0, 5'd0, 32'h1234_5000, 32'h123453B7, 1'b1);
    // Unmapped branch func3: flagged but still written.
    send(3'd3, 3'b101, 1'b0, 5'd0, 5'd3, 5'd4, 32'd16,
         model_word(3'd3, 3'b101, 1'b0, 5'd0, 5'd3, 5'd4, 32'd16), 1'b1);
    drain();
    n_cmp += 2;
    if (err !== 1'b1)   begin n_bad++; $display("FAIL branch_f3_err: %b, required 1", err); end
    if (count !== 3'd3) begin n_bad++; $display("FAIL branch_f3_count: %0d, required 3", count); end
    do_clear();
    n_cmp += 2;
    if (err !== 1'b0)   begin n_bad++; $display("FAIL clear_err: %b, required 0", err); end
    if (count !== 3'd0) begin n_bad++; $display("FAIL clear_count: %0d, required 0", count); end
  endtask

  task automatic test_random();
    logic [2:0]  c;
    logic [2:0]  f3;
    logic [31:0] imm;
    logic [31:0] r;
    logic [4:0]  rd, rs1, rs2;
    logic        f7;
    do_clear();
    for (int i = 0; i < 15; i++) begin
      c   = 3'($urandom_range(0, 7));
      f3  = (c == 3'd3) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
      f7  = 1'($urandom_range(0, 1));
      rd  = 5'($urandom_range(0, 31));
      rs1 = 5'($urandom_range(0, 31));
      rs2 = 5'($urandom_range(0, 31));
      r   = $urandom();
      case (c)
        3'd3:    imm = {{19{r[12]}}, r[12:1], 1'b0};
        3'd4:    imm = {r[31:12], 12'h000};
        3'd5:    imm = {{11{r[20]}}, r[20:1], 1'b0};
        default: imm = {{20{r[11]}}, r[11:0]};
      endcase
      send(c, f3, f7, rd, rs1, rs2, imm, model_word(c, f3, f7, rd, rs1, rs2, imm), 1'b1);
      if (exp_count == DEPTH - 1) begin
        drain();
        do_clear();
      end
    end
    drain();
    n_cmp++;
    if (err !== 1'b0) begin n_bad++; $display("FAIL random_err: %b, required 0", err); end
  endtask

  task automatic test_back_to_back();
    int w0;
    do_clear();
    for (int i = 0; i < DEPTH; i++)
      send(3'd1, 3'b000, 1'b0, 5'(i + 1), 5'd2, 5'd0, 32'(i),
           model_word(3'd1, 3'b000, 1'b0, 5'(i + 1), 5'd2, 5'd0, 32'(i)), 1'b1);
    drain();
    n_cmp += 3;
    if (full !== 1'b1)     begin n_bad++; $display("FAIL full_flag: %b, required 1", full); end
    if (in_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready: %b, required 0", in_ready); end
    if (count !== 3'd4)    begin n_bad++; $display("FAIL full_count: %0d, required 4", count); end
    w0 = n_writes;
    @(negedge clk);
    in_class = 3'd1; in_rd = 5'd9; in_imm = 32'd5; in_valid = 1'b1;
    wait_cycles(20);
    in_valid = 1'b0;
    n_cmp += 3;
    if (n_writes != w0)    begin n_bad++; $display("FAIL fifth_word: %0d writes, required %0d", n_writes, w0); end
    if (full !== 1'b1)     begin n_bad++; $display("FAIL full_hold: %b, required 1", full); end
    if (in_ready !== 1'b0) begin n_bad++; $display("FAIL full_hold_ready: %b, required 0", in_ready); end
    do_clear();
    n_cmp += 2;
    if (count !== 3'd0) begin n_bad++; $display("FAIL after_clear_count: %0d, required 0", count); end
    if (full !== 1'b0)  begin n_bad++; $display("FAIL after_clear_full: %b, required 0", full); end
    send(3'd0, 3'b111, 1'b1, 5'd4, 5'd5, 5'd6, 32'h0,
         model_word(3'd0, 3'b111, 1'b1, 5'd4, 5'd5, 5'd6, 32'h0), 1'b1);
    drain();
  endtask

  task automatic test_clear_enc();
    int w0;
    do_clear();
    w0 = n_writes;
    send(3'd1, 3'b010, 1'b0, 5'd8, 5'd9, 5'd0, 32'd77, 32'h0, 1'b0);
    n_cmp++;
    if (state !== 2'd1) begin n_bad++; $display("FAIL enc_state: %0d, required 1", state); end
    clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL clear_enc_ready: %b, required 1", in_ready); end
    wait_cycles(5);
    send(3'd1, 3'b010, 1'b0, 5'd8, 5'd9, 5'd0, 32'd77, 32'h0, 1'b0);
    @(posedge clk); #1 clear = 1'b1;
    #1;
    n_cmp++;
    if (imem_we !== 1'b0) begin n_bad++; $display("FAIL clear_wr_we: %b, required 0", imem_we); end
    @(posedge clk); #1 clear = 1'b0;
    wait_cycles(5);
    n_cmp += 2;
    if (n_writes != w0) begin n_bad++; $display("FAIL clear_discard: %0d writes, required %0d", n_writes, w0); end
    if (count !== 3'd0) begin n_bad++; $display("FAIL clear_discard_count: %0d, required 0", count); end
  endtask

  task automatic test_reset_wr();
    int w0;
    do_clear();
    send(3'd2, 3'b010, 1'b0, 5'd0, 5'd1, 5'd2, 32'd12,
         model_word(3'd2, 3'b010, 1'b0, 5'd0, 5'd1, 5'd2, 32'd12), 1'b1);
    drain();
    w0 = n_writes;
    send(3'd1, 3'b000, 1'b0, 5'd3, 5'd3, 5'd0, 32'd100, 32'h0, 1'b0);
    @(posedge clk); #1;
    n_cmp++;
    if (imem_we !== 1'b1) begin n_bad++; $display("FAIL pre_reset_we: %b, required 1", imem_we); end
    rst_n = 1'b0;
    #1;
    n_cmp += 6;
    if (imem_we !== 1'b0)     begin n_bad++; $display("FAIL rst_wr_we: %b, required 0", imem_we); end
    if (in_ready !== 1'b1)    begin n_bad++; $display("FAIL rst_wr_ready: %b, required 1", in_ready); end
    if (imem_addr !== BASE)   begin n_bad++; $display("FAIL rst_wr_addr: %h, required %h", imem_addr, BASE); end
    if (imem_wdata !== 32'h0) begin n_bad++; $display("FAIL rst_wr_wdata: %h, required 0", imem_wdata); end
    if (count !== 3'd0)       begin n_bad++; $display("FAIL rst_wr_count: %0d, required 0", count); end
    if (state !== 2'd0)       begin n_bad++; $display("FAIL rst_wr_state: %0d, required 0", state); end
    wait_cycles(2);
    rst_n = 1'b1;
    exp_count = 0;
    wait_cycles(4);
    n_cmp++;
    if (n_writes != w0) begin n_bad++; $display("FAIL rst_wr_abandon: %0d writes, required %0d", n_writes, w0); end
  endtask

  task automatic test_imm_range();
    int w0;
    do_clear();
    w0 = n_writes;
`ifdef INSTR_ENCODER_CHECK_EN
    send(3'd1, 3'b000, 1'b0, 5'd3, 5'd4, 5'd0, 32'd4096, 32'h0, 1'b0);
    wait_cycles(5);
    n_cmp += 4;
    if (err !== 1'b1)      begin n_bad++; $display("FAIL range_err: %b, required 1", err); end
    if (count !== 3'd0)    begin n_bad++; $display("FAIL range_count: %0d, required 0", count); end
    if (n_writes != w0)    begin n_bad++; $display("FAIL range_nowrite: %0d, required %0d", n_writes, w0); end
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL range_ready: %b, required 1", in_ready); end
`else
    send(3'd1, 3'b000, 1'b0, 5'd3, 5'd4, 5'd0, 32'd4096, 32'h00020193, 1'b1);
    drain();
    n_cmp += 3;
    if (err !== 1'b0)        begin n_bad++; $display("FAIL trunc_err: %b, required 0", err); end
    if (count !== 3'd1)      begin n_bad++; $display("FAIL trunc_count: %0d, required 1", count); end
    if (n_writes != w0 + 1)  begin n_bad++; $display("FAIL trunc_write: %0d, required %0d", n_writes, w0 + 1); end
`endif
  endtask

  // ---------------- main sequence / report ----------------
  initial begin
    n_cmp = 0; n_bad = 0; n_writes = 0; exp_count = 0;
    clear = 1'b0; in_valid = 1'b0;
    in_class = '0; in_func3 = '0; in_func7b5 = 1'b0;
    in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    test_reset();
    test_r_add();
    test_vectors();
    test_random();
    test_back_to_back();
    test_clear_enc();
    test_reset_wr();
    test_imm_range();
    wait_cycles(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
